// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipe_r_hs elastic pipeline.
//   DEF_LANES / DEF_WIDTH / DEF_DEPTH : default geometry (32 lanes x 9 bits, 2 stages)
//   occ_width(depth)                  : width of the occupancy count for a given depth
//   lane_lsb(lane, width)             : LSB position of a lane inside a packed beat
package pipe_pkg;

  localparam int DEF_LANES = 32;
  localparam int DEF_WIDTH = 9;
  localparam int DEF_DEPTH = 2;

  // Occupancy can reach DEPTH+1 when the skid entry is present, so size for
  // DEPTH+2 distinct values.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  localparam int DEF_OCC_W = occ_width(DEF_DEPTH);

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_r_hs_stage.sv
// pipe_r_hs_stage: one valid+data register of the elastic pipeline.
//   clk, rstb    : clock, synchronous active-low reset (clears valid and data)
//   flush        : clears valid only; data is left untouched
//   load         : stage advances this cycle (takes src_valid, data if src_valid)
//   src_valid/src_data : upstream stage (or pipeline input)
//   valid/data   : registered stage contents
module pipe_r_hs_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         flush,
  input  logic         load,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= src_valid;
      end
      // Data only moves with a real beat, so it stays stable across bubbles.
      if (load && src_valid && !flush) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/pipe_r_hs.sv
// pipe_r_hs: elastic pipeline register bank, LANES signed samples of WIDTH bits
// per beat through DEPTH stages, with bubble collapsing, flush and occupancy.
//   clk, rstb            : clock, synchronous active-low reset
//   flush                : drop every in-flight beat (data registers untouched)
//   in_valid/in_ready/d_r    : upstream beat handshake, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready/q_r  : downstream beat handshake, same lane packing
//   occ                  : registered count of beats held
// Optional macro PIPE_R_HS_SKID_EN: one-entry skid ahead of stage 0 so that
// in_ready comes straight from a flop instead of combinationally from out_ready.
//
// Handshake: a beat transfers on a cycle where valid & ready are both 1.
// The sender holds its data stable while valid=1 and ready=0; this block does
// so on q_r, and expects the same of d_r.
module pipe_r_hs
  import pipe_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     d_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*WIDTH-1:0]     q_r,
  output logic [$clog2(DEPTH+2)-1:0] occ
);

  localparam int W     = LANES * WIDTH;
  localparam int OCC_W = occ_width(DEPTH);

  logic         v    [DEPTH];
  logic [W-1:0] data [DEPTH];
  logic         adv  [DEPTH];

  logic         src_v;
  logic [W-1:0] src_d;

  // A stage advances if it is empty or the stage ahead advances; an empty
  // stage is overwritten, which is what collapses bubbles.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_last
      assign adv[k] = !v[k] | out_ready;
    end else begin : g_mid
      assign adv[k] = !v[k] | adv[k+1];
    end

    if (k == 0) begin : g_first
      pipe_r_hs_stage #(.W(W)) u_stage (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (flush),
        .load      (adv[k]),
        .src_valid (src_v),
        .src_data  (src_d),
        .valid     (v[k]),
        .data      (data[k])
      );
    end else begin : g_next
      pipe_r_hs_stage #(.W(W)) u_stage (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (flush),
        .load      (adv[k]),
        .src_valid (v[k-1]),
        .src_data  (data[k-1]),
        .valid     (v[k]),
        .data      (data[k])
      );
    end
  end

`ifdef PIPE_R_HS_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;

  // While the skid holds a beat, in_ready is low, so the skid always wins
  // stage 0 over new input.
  assign in_ready = !skid_valid;
  assign src_v    = skid_valid | in_valid;
  assign src_d    = skid_valid ? skid_data : d_r;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (flush) begin
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (adv[0]) skid_valid <= 1'b0;
      end else begin
        skid_valid <= in_valid & !adv[0];
      end
      // Accepted beat that stage 0 cannot take this cycle parks in the skid.
      if (!flush && !skid_valid && in_valid && !adv[0]) begin
        skid_data <= d_r;
      end
    end
  end
`else
  assign in_ready = adv[0];
  assign src_v    = in_valid;
  assign src_d    = d_r;
`endif

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

  assign out_valid = v[DEPTH-1];
  assign q_r       = data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Beats are never lost or duplicated, so occupancy is simply the running
  // balance of input and output transfers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_pipe_r_hs.sv
// tb_pipe_r_hs: randomized bench for pipe_r_hs. The reference is a FIFO of
// accepted beats with their acceptance cycle; a beat is expected at the output
// once DEPTH cycles have passed since acceptance and the previous beat has left.
module tb_pipe_r_hs;
  import pipe_pkg::*;

  localparam int LANES = DEF_LANES;
  localparam int WIDTH = DEF_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int W     = LANES * WIDTH;
  localparam int OW    = $clog2(DEPTH + 2);
`ifdef PIPE_R_HS_SKID_EN
  localparam int SKID  = 1;
`else
  localparam int SKID  = 0;
`endif
  localparam int MAXOCC = DEPTH + SKID;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  d_r = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  q_r;
  logic [OW-1:0] occ;

  always #5 clk = ~clk;

  pipe_r_hs #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_r       (d_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_r       (q_r),
    .occ       (occ)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  int seq       = 0;
  bit hold_beat = 1'b0;

  function automatic logic [W-1:0] make_beat(input bit seq_mode, input int s);
    logic [W-1:0]     b;
    logic [WIDTH-1:0] lane;
    b = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = seq_mode ? WIDTH'(s + i) : WIDTH'($urandom);
      b[lane_lsb(i, WIDTH) +: WIDTH] = lane;
    end
    return b;
  endfunction

  // One clock of stimulus; a beat not yet accepted is kept on d_r.
  task automatic step(input bit v, input bit rdy, input bit fl, input bit rb, input bit seq_mode);
    in_valid = v | hold_beat;
    if (!hold_beat && v) begin
      d_r = make_beat(seq_mode, seq);
      seq++;
    end
    out_ready = rdy;
    flush     = fl;
    rstb      = rb;
    @(negedge clk);
    hold_beat = in_valid && !in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (DEPTH + 6) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check(name, W'(occ), W'(0));
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           cyc      = 0;
  int           last_pop = -100;
  bit           rst_prev = 1'b0;
  bit           exp_ov;
  bit           exp_ir;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ov = 1'b0;
      if (exp_q.size() > 0) begin
        exp_ov = (cyc >= acc_q[0] + DEPTH) && (cyc >= last_pop + 1);
      end
      exp_ir = (SKID != 0) ? (exp_q.size() <= DEPTH)
                           : ((exp_q.size() < DEPTH) || out_ready);
      check("out_valid", W'(out_valid), W'(exp_ov));
      check("occ", W'(occ), W'(exp_q.size()));
      check("in_ready", W'(in_ready), W'(exp_ir));
      if (exp_ov) check("q_r", q_r, exp_q[0]);
      if (rst_prev) check("rst_q_r", q_r, W'(0));

      if (!rstb) begin
        exp_q.delete();
        acc_q.delete();
        last_pop = -100;
      end else begin
        if (exp_ov && out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          last_pop = cyc;
        end
        if (in_valid && exp_ir && !flush) begin
          exp_q.push_back(d_r);
          acc_q.push_back(cyc);
        end
        if (flush) begin
          exp_q.delete();
          acc_q.delete();
        end
      end
      rst_prev = !rstb;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] neg;
    neg = '0;
    neg[WIDTH-1] = 1'b1;

    // Reset held two cycles with a -256 beat offered on every lane.
    rstb      = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) d_r[lane_lsb(i, WIDTH) +: WIDTH] = neg;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_q_r", q_r, W'(0));
    check("rst_occ", W'(occ), W'(0));
    in_valid  = 1'b0;
    hold_beat = 1'b0;

    // Streaming: lane i = seq+i, wrapping through -256/+255.
    seq = 200;
    repeat (100) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain("stream_drain");

    // Backpressure: stall the output while upstream keeps offering.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_occ", W'(occ), W'(MAXOCC));
    check("bp_in_ready", W'(in_ready), W'(0));
    drain("bp_drain");

    // Bubbles with random downstream readiness.
    for (int c = 0; c < 300; c++) begin
      step(c[0] == 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    end
    drain("bubble_drain");

    // Flush with DEPTH beats held and a beat transferring in the same cycle.
    repeat (DEPTH) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_flush_occ", W'(occ), W'(DEPTH));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_occ", W'(occ), W'(0));
    check("flush_out_valid", W'(out_valid), W'(0));
    repeat (20) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    drain("flush_drain");

    // Reset pulsed in the middle of a burst.
    for (int c = 0; c < 60; c++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, c != 30, 1'b1);
    end
    drain("midrst_drain");

    check("sb_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
